instruction_decode: RTL and testbench



---
 rtl/instruction_decode_pkg.sv | 67 ++++++
 rtl/instruction_decode_register_file.sv | 51 +++++
 rtl/instruction_decode.sv | 240 ++++++++++++++++++++++++
 tb/tb_instruction_decode.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_decode_pkg.sv
// Shared decode constants for the ID stage: opcodes, funct codes, ALUOp and
// branch encodings, the HALT word and the control bundle type.
package instruction_decode_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LB    = 6'h20,
        OP_LH    = 6'h21,
        OP_LW    = 6'h23,
        OP_LBU   = 6'h24,
        OP_LHU   = 6'h25,
        OP_LWU   = 6'h27,
        OP_SB    = 6'h28,
        OP_SH    = 6'h29,
        OP_SW    = 6'h2B
    } opcode_e;

    localparam logic [5:0]  FUNCT_JR   = 6'h08;
    localparam logic [5:0]  FUNCT_JALR = 6'h09;
    localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_IMM   = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JUMP = 2'b11
    } branch_e;

    typedef struct packed {
        logic    mem_to_reg;
        logic    reg_write;
        logic    mem_write;
        logic    mem_read;
        logic    alu_src;
        branch_e branch;
        aluop_e  alu_op;
        logic    halt;
    } ctrl_t;

    // Logical immediates and LUI take the raw 16 bits; everything else sign-extends.
    function automatic logic is_zero_ext(input logic [5:0] op);
        logic zext;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: zext = 1'b1;
            default:                          zext = 1'b0;
        endcase
        return zext;
    endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32-entry register file, two read ports and one write port with write-through;
// r0 is hard-wired to zero.
module instruction_decode_register_file #(
    parameter int N_BITS     = 32,
    parameter int N_REG_BITS = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic [N_REG_BITS-1:0] i_waddr,
    input  logic [N_BITS-1:0]     i_wdata,
    input  logic [N_REG_BITS-1:0] i_raddr1,
    input  logic [N_REG_BITS-1:0] i_raddr2,
    output logic [N_BITS-1:0]     o_rdata1,
    output logic [N_BITS-1:0]     o_rdata2
);

    localparam int DEPTH = 2 ** N_REG_BITS;

    logic [N_BITS-1:0] regs_r [DEPTH];

    // Storage: reset clears every entry and beats a same-cycle write.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else if (i_we && (i_waddr != {N_REG_BITS{1'b0}})) begin
            regs_r[i_waddr] <= i_wdata;
        end
    end

    // Read ports with write-through so WB and ID can share a cycle.
    always_comb begin
        if (i_raddr1 == {N_REG_BITS{1'b0}}) begin
            o_rdata1 = '0;
        end else if (i_we && (i_waddr == i_raddr1)) begin
            o_rdata1 = i_wdata;
        end else begin
            o_rdata1 = regs_r[i_raddr1];
        end
        if (i_raddr2 == {N_REG_BITS{1'b0}}) begin
            o_rdata2 = '0;
        end else if (i_we && (i_waddr == i_raddr2)) begin
            o_rdata2 = i_wdata;
        end else begin
            o_rdata2 = regs_r[i_raddr2];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: register file, control decode, branch/jump resolution with EX/MEM
// forwarding, load-use stall and the ID/EX pipeline register. ID_HALT_EN enables HALT.
module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int N_BITS     = 32,
    parameter int N_REG_BITS = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [N_BITS-1:0]     i_instruccion,
    input  logic [N_BITS-1:0]     i_pc_4,
    input  logic                  i_regWrite,
    input  logic [N_REG_BITS-1:0] i_dato_a_escribir_addr,
    input  logic [N_BITS-1:0]     i_WB_data_to_w,
    input  logic [N_REG_BITS-1:0] i_ID_EX_rt,
    input  logic                  i_ID_EX_MemRead,
    input  logic                  i_control_M_memRead_ID_EX,
    input  logic                  i_control_WB_regWrite_ex,
    input  logic                  i_control_WB_regWrite_mem,
    input  logic [N_REG_BITS-1:0] i_Alu_rt,
    input  logic [N_REG_BITS-1:0] i_Mem_rt,
    input  logic [N_BITS-1:0]     i_dato_salida_ALU,
    input  logic [N_BITS-1:0]     i_dato_salida_mem,
    output logic [N_BITS-1:0]     o_dato_leido1,
    output logic [N_BITS-1:0]     o_dato_leido2,
    output logic [N_REG_BITS-1:0] o_rs,
    output logic [N_REG_BITS-1:0] o_rd_or_rt,
    output logic [N_BITS-1:0]     o_dato_ex_signo,
    output logic [N_BITS-1:0]     o_sign_extension,
    output logic                  o_control_WB_memtoReg,
    output logic                  o_control_WB_regWrite,
    output logic                  o_control_M_memWrite,
    output logic                  o_control_M_memRead,
    output logic                  o_control_EX_ALUSrc,
    output logic [1:0]            o_control_M_branch,
    output logic [1:0]            o_control_EX_ALUOp,
    output logic [N_BITS-1:0]     o_jump_direction,
    output logic                  o_flush,
    output logic                  o_stall,
    output logic                  o_halt
);

    localparam logic [N_REG_BITS-1:0] REG_ZERO = {N_REG_BITS{1'b0}};
    localparam logic [N_REG_BITS-1:0] REG_RA   = {N_REG_BITS{1'b1}};

    logic [5:0]            opcode_s;
    logic [5:0]            funct_s;
    logic [N_REG_BITS-1:0] rs_s, rt_s, rd_s, dest_s;
    logic [15:0]           imm_s;
    logic [N_BITS-1:0]     rf_rs_s, rf_rt_s, fwd_rs_s, fwd_rt_s, ext_s, target_s;
    logic                  link_s, is_jr_s, redirect_s, reads_rs_s, reads_rt_s;
    logic                  load_use_s, mem_load_s;
    ctrl_t                 ctrl_s, ctrl_q_s;

    assign opcode_s = i_instruccion[31:26];
    assign rs_s     = i_instruccion[25:21];
    assign rt_s     = i_instruccion[20:16];
    assign rd_s     = i_instruccion[15:11];
    assign funct_s  = i_instruccion[5:0];
    assign imm_s    = i_instruccion[15:0];

    instruction_decode_register_file #(
        .N_BITS     (N_BITS),
        .N_REG_BITS (N_REG_BITS)
    ) u_register_file (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_we     (i_regWrite),
        .i_waddr  (i_dato_a_escribir_addr),
        .i_wdata  (i_WB_data_to_w),
        .i_raddr1 (rs_s),
        .i_raddr2 (rt_s),
        .o_rdata1 (rf_rs_s),
        .o_rdata2 (rf_rt_s)
    );

    assign ext_s = is_zero_ext(opcode_s) ? {{(N_BITS-16){1'b0}}, imm_s}
                                         : {{(N_BITS-16){imm_s[15]}}, imm_s};
    assign o_sign_extension = ext_s;

    // Control decode; the HALT word is checked first so it never aliases a real opcode.
    always_comb begin
        ctrl_s  = '0;
        dest_s  = rt_s;
        link_s  = 1'b0;
        is_jr_s = 1'b0;
        if (i_instruccion == HALT_WORD) begin
`ifdef ID_HALT_EN
            ctrl_s.halt = 1'b1;
`else
            ctrl_s.halt = 1'b0;
`endif
        end else begin
            case (opcode_e'(opcode_s))
                OP_RTYPE: begin
                    dest_s        = rd_s;
                    ctrl_s.alu_op = ALUOP_RTYPE;
                    if (funct_s == FUNCT_JR) begin
                        ctrl_s.branch = BR_JUMP;
                        is_jr_s       = 1'b1;
                    end else if (funct_s == FUNCT_JALR) begin
                        ctrl_s.branch    = BR_JUMP;
                        ctrl_s.reg_write = 1'b1;
                        is_jr_s          = 1'b1;
                        link_s           = 1'b1;
                    end else begin
                        ctrl_s.reg_write = 1'b1;
                    end
                end
                OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
                    ctrl_s.mem_read   = 1'b1;
                    ctrl_s.mem_to_reg = 1'b1;
                    ctrl_s.reg_write  = 1'b1;
                    ctrl_s.alu_src    = 1'b1;
                    ctrl_s.alu_op     = ALUOP_ADD;
                end
                OP_SB, OP_SH, OP_SW: begin
                    ctrl_s.mem_write = 1'b1;
                    ctrl_s.alu_src   = 1'b1;
                    ctrl_s.alu_op    = ALUOP_ADD;
                end
                OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                    ctrl_s.reg_write = 1'b1;
                    ctrl_s.alu_src   = 1'b1;
                    ctrl_s.alu_op    = ALUOP_IMM;
                end
                OP_BEQ: begin
                    ctrl_s.branch = BR_BEQ;
                    ctrl_s.alu_op = ALUOP_SUB;
                end
                OP_BNE: begin
                    ctrl_s.branch = BR_BNE;
                    ctrl_s.alu_op = ALUOP_SUB;
                end
                OP_J: begin
                    ctrl_s.branch = BR_JUMP;
                end
                OP_JAL: begin
                    ctrl_s.branch    = BR_JUMP;
                    ctrl_s.reg_write = 1'b1;
                    dest_s           = REG_RA;
                    link_s           = 1'b1;
                end
                default: begin
                    ctrl_s = '0;
                end
            endcase
        end
    end

    // Branch operand forwarding: EX result beats MEM result beats register file.
    always_comb begin
        if (i_control_WB_regWrite_ex && (i_Alu_rt == rs_s) && (rs_s != REG_ZERO)) begin
            fwd_rs_s = i_dato_salida_ALU;
        end else if (i_control_WB_regWrite_mem && (i_Mem_rt == rs_s) && (rs_s != REG_ZERO)) begin
            fwd_rs_s = i_dato_salida_mem;
        end else begin
            fwd_rs_s = rf_rs_s;
        end
        if (i_control_WB_regWrite_ex && (i_Alu_rt == rt_s) && (rt_s != REG_ZERO)) begin
            fwd_rt_s = i_dato_salida_ALU;
        end else if (i_control_WB_regWrite_mem && (i_Mem_rt == rt_s) && (rt_s != REG_ZERO)) begin
            fwd_rt_s = i_dato_salida_mem;
        end else begin
            fwd_rt_s = rf_rt_s;
        end
    end

    // Hazards: a load in EX feeding anything, or a load in MEM feeding a branch/JR.
    assign reads_rt_s = (ctrl_s.branch == BR_BEQ) || (ctrl_s.branch == BR_BNE);
    assign reads_rs_s = reads_rt_s || is_jr_s;
    assign load_use_s = i_ID_EX_MemRead && (i_ID_EX_rt != REG_ZERO)
                        && ((i_ID_EX_rt == rs_s) || (i_ID_EX_rt == rt_s));
    assign mem_load_s = i_control_M_memRead_ID_EX && (i_Mem_rt != REG_ZERO)
                        && ((reads_rs_s && (i_Mem_rt == rs_s)) || (reads_rt_s && (i_Mem_rt == rt_s)));
    assign o_stall    = load_use_s || mem_load_s;

    // Redirect resolution and target selection.
    always_comb begin
        redirect_s = 1'b0;
        target_s   = '0;
        case (ctrl_s.branch)
            BR_BEQ: begin
                redirect_s = (fwd_rs_s == fwd_rt_s);
                target_s   = i_pc_4 + {ext_s[N_BITS-3:0], 2'b00};
            end
            BR_BNE: begin
                redirect_s = (fwd_rs_s != fwd_rt_s);
                target_s   = i_pc_4 + {ext_s[N_BITS-3:0], 2'b00};
            end
            BR_JUMP: begin
                redirect_s = 1'b1;
                target_s   = is_jr_s ? fwd_rs_s : {i_pc_4[N_BITS-1:N_BITS-4], i_instruccion[25:0], 2'b00};
            end
            default: begin
                redirect_s = 1'b0;
                target_s   = '0;
            end
        endcase
    end

    assign o_flush          = redirect_s && !o_stall;
    assign o_jump_direction = o_flush ? target_s : '0;
    assign ctrl_q_s         = o_stall ? ctrl_t'('0) : ctrl_s;

    // ID/EX pipeline register; a stall loads a bubble into the control fields.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_dato_leido1         <= '0;
            o_dato_leido2         <= '0;
            o_rs                  <= '0;
            o_rd_or_rt            <= '0;
            o_dato_ex_signo       <= '0;
            o_control_WB_memtoReg <= 1'b0;
            o_control_WB_regWrite <= 1'b0;
            o_control_M_memWrite  <= 1'b0;
            o_control_M_memRead   <= 1'b0;
            o_control_EX_ALUSrc   <= 1'b0;
            o_control_M_branch    <= 2'b00;
            o_control_EX_ALUOp    <= 2'b00;
            o_halt                <= 1'b0;
        end else begin
            o_dato_leido1         <= link_s ? i_pc_4 : rf_rs_s;
            o_dato_leido2         <= rf_rt_s;
            o_rs                  <= rs_s;
            o_rd_or_rt            <= dest_s;
            o_dato_ex_signo       <= ext_s;
            o_control_WB_memtoReg <= ctrl_q_s.mem_to_reg;
            o_control_WB_regWrite <= ctrl_q_s.reg_write;
            o_control_M_memWrite  <= ctrl_q_s.mem_write;
            o_control_M_memRead   <= ctrl_q_s.mem_read;
            o_control_EX_ALUSrc   <= ctrl_q_s.alu_src;
            o_control_M_branch    <= ctrl_q_s.branch;
            o_control_EX_ALUOp    <= ctrl_q_s.alu_op;
            o_halt                <= ctrl_q_s.halt;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode, register file, forwarding,
// stalls, redirects, reset and HALT (expected HALT value follows ID_HALT_EN).
module tb_instruction_decode;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_instruccion, i_pc_4, i_WB_data_to_w, i_dato_salida_ALU, i_dato_salida_mem;
    logic        i_regWrite, i_ID_EX_MemRead, i_control_M_memRead_ID_EX;
    logic        i_control_WB_regWrite_ex, i_control_WB_regWrite_mem;
    logic [4:0]  i_dato_a_escribir_addr, i_ID_EX_rt, i_Alu_rt, i_Mem_rt;
    logic [31:0] o_dato_leido1, o_dato_leido2, o_dato_ex_signo, o_sign_extension, o_jump_direction;
    logic [4:0]  o_rs, o_rd_or_rt;
    logic        o_control_WB_memtoReg, o_control_WB_regWrite, o_control_M_memWrite;
    logic        o_control_M_memRead, o_control_EX_ALUSrc, o_flush, o_stall, o_halt;
    logic [1:0]  o_control_M_branch, o_control_EX_ALUOp;

    int n_cmp = 0;
    int n_err = 0;

`ifdef ID_HALT_EN
    localparam logic EXP_HALT = 1'b1;
`else
    localparam logic EXP_HALT = 1'b0;
`endif

    instruction_decode dut (
        .i_clk                     (i_clk),
        .i_reset                   (i_reset),
        .i_instruccion             (i_instruccion),
        .i_pc_4                    (i_pc_4),
        .i_regWrite                (i_regWrite),
        .i_dato_a_escribir_addr    (i_dato_a_escribir_addr),
        .i_WB_data_to_w            (i_WB_data_to_w),
        .i_ID_EX_rt                (i_ID_EX_rt),
        .i_ID_EX_MemRead           (i_ID_EX_MemRead),
        .i_control_M_memRead_ID_EX (i_control_M_memRead_ID_EX),
        .i_control_WB_regWrite_ex  (i_control_WB_regWrite_ex),
        .i_control_WB_regWrite_mem (i_control_WB_regWrite_mem),
        .i_Alu_rt                  (i_Alu_rt),
        .i_Mem_rt                  (i_Mem_rt),
        .i_dato_salida_ALU         (i_dato_salida_ALU),
        .i_dato_salida_mem         (i_dato_salida_mem),
        .o_dato_leido1             (o_dato_leido1),
        .o_dato_leido2             (o_dato_leido2),
        .o_rs                      (o_rs),
        .o_rd_or_rt                (o_rd_or_rt),
        .o_dato_ex_signo           (o_dato_ex_signo),
        .o_sign_extension          (o_sign_extension),
        .o_control_WB_memtoReg     (o_control_WB_memtoReg),
        .o_control_WB_regWrite     (o_control_WB_regWrite),
        .o_control_M_memWrite      (o_control_M_memWrite),
        .o_control_M_memRead       (o_control_M_memRead),
        .o_control_EX_ALUSrc       (o_control_EX_ALUSrc),
        .o_control_M_branch        (o_control_M_branch),
        .o_control_EX_ALUOp        (o_control_EX_ALUOp),
        .o_jump_direction          (o_jump_direction),
        .o_flush                   (o_flush),
        .o_stall                   (o_stall),
        .o_halt                    (o_halt)
    );

    always #5 i_clk = ~i_clk;

    task automatic idle();
        i_instruccion = 32'h0; i_pc_4 = 32'h0;
        i_regWrite = 1'b0; i_dato_a_escribir_addr = 5'd0; i_WB_data_to_w = 32'h0;
        i_ID_EX_rt = 5'd0; i_ID_EX_MemRead = 1'b0; i_control_M_memRead_ID_EX = 1'b0;
        i_control_WB_regWrite_ex = 1'b0; i_control_WB_regWrite_mem = 1'b0;
        i_Alu_rt = 5'd0; i_Mem_rt = 5'd0; i_dato_salida_ALU = 32'h0; i_dato_salida_mem = 32'h0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        i_reset = 1'b1;
        tick();
        n_cmp++; if (o_control_WB_regWrite !== 1'b0) begin n_err++; $display("FAIL reset_regwrite: got %b want 0", o_control_WB_regWrite); end
        n_cmp++; if (o_dato_leido1 !== 32'h0) begin n_err++; $display("FAIL reset_leido1: got %h want 0", o_dato_leido1); end
        n_cmp++; if (o_halt !== 1'b0) begin n_err++; $display("FAIL reset_halt: got %b want 0", o_halt); end
        n_cmp++; if ({o_flush, o_stall} !== 2'b00) begin n_err++; $display("FAIL reset_flush_stall: got %b want 00", {o_flush, o_stall}); end
        i_reset = 1'b0;
    endtask

    task automatic test_rtype();
        idle();
        i_regWrite = 1'b1; i_dato_a_escribir_addr = 5'd1; i_WB_data_to_w = 32'd5;
        tick();
        i_dato_a_escribir_addr = 5'd2;
        tick();
        i_regWrite = 1'b0;
        i_instruccion = 32'h0022_1824;
        tick();
        n_cmp++; if (o_rs !== 5'd1) begin n_err++; $display("FAIL and_rs: got %0d want 1", o_rs); end
        n_cmp++; if (o_rd_or_rt !== 5'd3) begin n_err++; $display("FAIL and_rd: got %0d want 3", o_rd_or_rt); end
        n_cmp++; if (o_dato_leido1 !== 32'd5) begin n_err++; $display("FAIL and_leido1: got %h want 5", o_dato_leido1); end
        n_cmp++; if (o_dato_leido2 !== 32'd5) begin n_err++; $display("FAIL and_leido2: got %h want 5", o_dato_leido2); end
        n_cmp++; if (o_control_EX_ALUOp !== 2'b10) begin n_err++; $display("FAIL and_aluop: got %b want 10", o_control_EX_ALUOp); end
        n_cmp++; if ({o_control_WB_regWrite, o_control_EX_ALUSrc, o_control_M_memRead} !== 3'b100) begin
            n_err++; $display("FAIL and_ctrl: got %b want 100", {o_control_WB_regWrite, o_control_EX_ALUSrc, o_control_M_memRead});
        end
    endtask

    task automatic test_load_store();
        idle();
        i_instruccion = 32'h8063_0001;
        tick();
        n_cmp++; if ({o_control_M_memRead, o_control_WB_memtoReg, o_control_EX_ALUSrc, o_control_WB_regWrite} !== 4'b1111) begin
            n_err++; $display("FAIL lb_ctrl: got %b want 1111", {o_control_M_memRead, o_control_WB_memtoReg, o_control_EX_ALUSrc, o_control_WB_regWrite});
        end
        n_cmp++; if (o_control_EX_ALUOp !== 2'b00) begin n_err++; $display("FAIL lb_aluop: got %b want 00", o_control_EX_ALUOp); end
        n_cmp++; if (o_rd_or_rt !== 5'd3) begin n_err++; $display("FAIL lb_rt: got %0d want 3", o_rd_or_rt); end
        n_cmp++; if (o_dato_ex_signo !== 32'd1) begin n_err++; $display("FAIL lb_imm: got %h want 1", o_dato_ex_signo); end
        i_instruccion = 32'hAC43_0008;
        tick();
        n_cmp++; if ({o_control_M_memWrite, o_control_WB_regWrite, o_control_M_memRead, o_control_EX_ALUSrc} !== 4'b1001) begin
            n_err++; $display("FAIL sw_ctrl: got %b want 1001", {o_control_M_memWrite, o_control_WB_regWrite, o_control_M_memRead, o_control_EX_ALUSrc});
        end
    endtask

    task automatic test_immediate();
        idle();
        i_instruccion = 32'h3021_014A;
        tick();
        n_cmp++; if (o_control_EX_ALUOp !== 2'b11) begin n_err++; $display("FAIL andi_aluop: got %b want 11", o_control_EX_ALUOp); end
        n_cmp++; if (o_dato_ex_signo !== 32'h0000_014A) begin n_err++; $display("FAIL andi_imm: got %h want 0000014a", o_dato_ex_signo); end
        i_instruccion = 32'h3021_8001;
        #1;
        n_cmp++; if (o_sign_extension !== 32'h0000_8001) begin n_err++; $display("FAIL andi_zext: got %h want 00008001", o_sign_extension); end
        i_instruccion = 32'h2021_FFFF;
        #1;
        n_cmp++; if (o_sign_extension !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL addi_sext_comb: got %h want ffffffff", o_sign_extension); end
        tick();
        n_cmp++; if (o_dato_ex_signo !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL addi_imm: got %h want ffffffff", o_dato_ex_signo); end
    endtask

    task automatic test_load_use_stall();
        idle();
        i_instruccion = 32'h0022_1824;
        i_ID_EX_MemRead = 1'b1; i_ID_EX_rt = 5'd2;
        #1;
        n_cmp++; if ({o_stall, o_flush} !== 2'b10) begin n_err++; $display("FAIL lu_stall: got %b want 10", {o_stall, o_flush}); end
        tick();
        n_cmp++; if ({o_control_WB_regWrite, o_control_EX_ALUOp} !== 3'b000) begin
            n_err++; $display("FAIL lu_bubble: got %b want 000", {o_control_WB_regWrite, o_control_EX_ALUOp});
        end
        i_ID_EX_rt = 5'd0;
        #1;
        n_cmp++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL lu_r0: got %b want 0", o_stall); end
        tick();
        n_cmp++; if (o_control_WB_regWrite !== 1'b1) begin n_err++; $display("FAIL lu_release: got %b want 1", o_control_WB_regWrite); end
    endtask

    task automatic test_branch();
        idle();
        i_instruccion = 32'h1022_0004; i_pc_4 = 32'd4;
        i_control_WB_regWrite_ex = 1'b1; i_Alu_rt = 5'd1; i_dato_salida_ALU = 32'd5;
        #1;
        n_cmp++; if (o_flush !== 1'b1) begin n_err++; $display("FAIL beq_flush: got %b want 1", o_flush); end
        n_cmp++; if (o_jump_direction !== 32'd20) begin n_err++; $display("FAIL beq_target: got %h want 14", o_jump_direction); end
        tick();
        n_cmp++; if ({o_control_M_branch, o_control_EX_ALUOp, o_control_WB_regWrite} !== 5'b01010) begin
            n_err++; $display("FAIL beq_ctrl: got %b want 01010", {o_control_M_branch, o_control_EX_ALUOp, o_control_WB_regWrite});
        end
        i_dato_salida_ALU = 32'd6;
        #1;
        n_cmp++; if ({o_flush, o_jump_direction} !== 33'h0) begin n_err++; $display("FAIL beq_not_taken: got %b/%h want 0/0", o_flush, o_jump_direction); end
        i_instruccion = 32'h1422_0004;
        #1;
        n_cmp++; if ({o_flush, o_jump_direction} !== {1'b1, 32'd20}) begin n_err++; $display("FAIL bne_taken: got %b/%h want 1/14", o_flush, o_jump_direction); end
        i_instruccion = 32'h1022_0004; i_control_WB_regWrite_ex = 1'b0;
        i_control_M_memRead_ID_EX = 1'b1; i_Mem_rt = 5'd2;
        #1;
        n_cmp++; if ({o_stall, o_flush, o_jump_direction} !== {2'b10, 32'h0}) begin
            n_err++; $display("FAIL beq_mem_load: got %b%b/%h want 10/0", o_stall, o_flush, o_jump_direction);
        end
        tick();
    endtask

    task automatic test_jump();
        idle();
        i_instruccion = 32'h0800_0010; i_pc_4 = 32'h1000_0004;
        #1;
        n_cmp++; if ({o_flush, o_jump_direction} !== {1'b1, 32'h1000_0040}) begin n_err++; $display("FAIL j_target: got %b/%h want 1/10000040", o_flush, o_jump_direction); end
        i_instruccion = 32'h0C00_0010;
        tick();
        n_cmp++; if ({o_rd_or_rt, o_control_WB_regWrite, o_control_M_branch} !== {5'd31, 1'b1, 2'b11}) begin
            n_err++; $display("FAIL jal_ctrl: got %0d/%b/%b want 31/1/11", o_rd_or_rt, o_control_WB_regWrite, o_control_M_branch);
        end
        n_cmp++; if (o_dato_leido1 !== 32'h1000_0004) begin n_err++; $display("FAIL jal_link: got %h want 10000004", o_dato_leido1); end
        i_instruccion = 32'h0020_0008;
        i_control_WB_regWrite_mem = 1'b1; i_Mem_rt = 5'd1; i_dato_salida_mem = 32'h400;
        #1;
        n_cmp++; if ({o_flush, o_jump_direction} !== {1'b1, 32'h400}) begin n_err++; $display("FAIL jr_mem_fwd: got %b/%h want 1/400", o_flush, o_jump_direction); end
        i_control_WB_regWrite_ex = 1'b1; i_Alu_rt = 5'd1; i_dato_salida_ALU = 32'h800;
        #1;
        n_cmp++; if (o_jump_direction !== 32'h800) begin n_err++; $display("FAIL jr_ex_priority: got %h want 800", o_jump_direction); end
        tick();
    endtask

    task automatic test_write_through();
        idle();
        i_regWrite = 1'b1; i_dato_a_escribir_addr = 5'd4; i_WB_data_to_w = 32'h77;
        i_instruccion = 32'h0080_1024;
        tick();
        n_cmp++; if (o_dato_leido1 !== 32'h77) begin n_err++; $display("FAIL wt_bypass: got %h want 77", o_dato_leido1); end
        i_dato_a_escribir_addr = 5'd0; i_WB_data_to_w = 32'h99;
        i_instruccion = 32'h0000_1024;
        tick();
        n_cmp++; if ({o_dato_leido1, o_dato_leido2} !== 64'h0) begin n_err++; $display("FAIL wt_r0: got %h/%h want 0/0", o_dato_leido1, o_dato_leido2); end
        i_regWrite = 1'b0;
        i_instruccion = 32'h0080_1024;
        tick();
        n_cmp++; if (o_dato_leido1 !== 32'h77) begin n_err++; $display("FAIL wt_stored: got %h want 77", o_dato_leido1); end
    endtask

    task automatic test_halt();
        idle();
        i_instruccion = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (o_flush !== 1'b0) begin n_err++; $display("FAIL halt_flush: got %b want 0", o_flush); end
        tick();
        n_cmp++; if (o_halt !== EXP_HALT) begin n_err++; $display("FAIL halt_flag: got %b want %b", o_halt, EXP_HALT); end
        n_cmp++; if ({o_control_WB_regWrite, o_control_M_memRead, o_control_M_branch, o_control_EX_ALUOp} !== 6'b0) begin
            n_err++; $display("FAIL halt_ctrl: got %b want 000000", {o_control_WB_regWrite, o_control_M_memRead, o_control_M_branch, o_control_EX_ALUOp});
        end
        i_instruccion = 32'h0;
        tick();
        n_cmp++; if (o_halt !== 1'b0) begin n_err++; $display("FAIL halt_clear: got %b want 0", o_halt); end
    endtask

    task automatic test_reset_midstream();
        idle();
        i_instruccion = 32'h0022_1824;
        i_reset = 1'b1;
        i_regWrite = 1'b1; i_dato_a_escribir_addr = 5'd5; i_WB_data_to_w = 32'h55;
        tick();
        n_cmp++; if ({o_control_WB_regWrite, o_rs, o_dato_leido2} !== 38'h0) begin
            n_err++; $display("FAIL rst_mid: got %b/%0d/%h want 0/0/0", o_control_WB_regWrite, o_rs, o_dato_leido2);
        end
        i_reset = 1'b0; i_regWrite = 1'b0;
        i_instruccion = 32'h00A2_1824;
        tick();
        n_cmp++; if ({o_dato_leido1, o_dato_leido2} !== 64'h0) begin n_err++; $display("FAIL rst_regs_cleared: got %h/%h want 0/0", o_dato_leido1, o_dato_leido2); end
        n_cmp++; if (o_control_WB_regWrite !== 1'b1) begin n_err++; $display("FAIL rst_resume: got %b want 1", o_control_WB_regWrite); end
    endtask

    initial begin
        idle();
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        test_reset();
        test_rtype();
        test_load_store();
        test_immediate();
        test_load_use_stall();
        test_branch();
        test_jump();
        test_write_through();
        test_halt();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
